// File: rtl/mult_control.sv
// Control FSM for the shift-add signed multiplier: clear/load, per-bit add/sub, shift, done.
// Optional build macro MULT_SKIP_ZERO_EN folds the shift into the ADD cycle when M=0.
module mult_control #(
  parameter int unsigned WIDTH = 8
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Run,
  input  logic ClearA_LoadB,
  input  logic M,
  output logic clr_ld,
  output logic clear_xa,
  output logic add,
  output logic sub,
  output logic shift,
  output logic busy,
  output logic done
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StClr,
    StAdd,
    StShift,
    StHold
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            last_bit;

  assign last_bit = (cnt_q == CntLast);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        // Run wins over ClearA_LoadB when both are high
        if (Run) begin
          state_d = StClr;
        end else if (ClearA_LoadB) begin
          state_d = StLoad;
        end
      end
      StLoad: state_d = StIdle;
      StClr: begin
        cnt_d   = '0;
        state_d = StAdd;
      end
      StAdd: begin
`ifdef MULT_SKIP_ZERO_EN
        if (!M) begin
          if (last_bit) begin
            state_d = StHold;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = StAdd;
          end
        end else begin
          state_d = StShift;
        end
`else
        state_d = StShift;
`endif
      end
      StShift: begin
        if (last_bit) begin
          state_d = StHold;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = StAdd;
        end
      end
      // Wait for Run to drop so a held Run cannot retrigger
      StHold: begin
        if (!Run) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    clr_ld   = 1'b0;
    clear_xa = 1'b0;
    add      = 1'b0;
    sub      = 1'b0;
    shift    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StIdle: ;
      StLoad: clr_ld = 1'b1;
      StClr: begin
        clear_xa = 1'b1;
        busy     = 1'b1;
      end
      StAdd: begin
        busy = 1'b1;
        add  = M & ~last_bit;
        sub  = M & last_bit;
`ifdef MULT_SKIP_ZERO_EN
        shift = ~M;
`endif
      end
      StShift: begin
        shift = 1'b1;
        busy  = 1'b1;
      end
      StHold: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mult_control.sv
// Randomized bench for mult_control: a per-run output schedule model plus literal pin checks.
module tb_mult_control;
  localparam int unsigned W = 8;
`ifdef MULT_SKIP_ZERO_EN
  localparam bit Skip = 1'b1;
`else
  localparam bit Skip = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic Run = 1'b0;
  logic ClearA_LoadB = 1'b0;
  logic M = 1'b0;
  logic clr_ld, clear_xa, add, sub, shift, busy, done;
  logic [6:0] outs;

  mult_control #(.WIDTH(W)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Run(Run),
    .ClearA_LoadB(ClearA_LoadB),
    .M(M),
    .clr_ld(clr_ld),
    .clear_xa(clear_xa),
    .add(add),
    .sub(sub),
    .shift(shift),
    .busy(busy),
    .done(done)
  );

  always #5 Clk = ~Clk;
  assign outs = {clr_ld, clear_xa, add, sub, shift, busy, done};

  // One entry per cycle: M to drive and the output vector that cycle must show
  typedef struct packed {
    logic       last;
    logic       m;
    logic [6:0] o;
  } ent_t;

  ent_t sched[$];
  ent_t exp_e;
  logic in_hold = 1'b0;
  logic chk_en = 1'b0;
  logic drv_done = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   bits_mode = 0;

  function automatic logic [6:0] ov(input bit cl, input bit cx, input bit a, input bit s,
                                    input bit sh, input bit b, input bit d);
    return {cl, cx, a, s, sh, b, d};
  endfunction

  function automatic logic rbit();
    return ($urandom % 2) == 1;
  endfunction

  task automatic lit(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic build_run();
    ent_t e;
    logic b;
    e = '0;
    e.m = rbit();
    e.o = ov(0, 1, 0, 0, 0, 1, 0);
    sched.push_back(e);
    for (int k = 0; k < int'(W); k++) begin
      case (bits_mode)
        1:       b = 1'b1;
        2:       b = 1'b0;
        3:       b = (k % 2) == 0;
        default: b = rbit();
      endcase
      e = '0;
      e.m = b;
      if (Skip && !b) begin
        e.o = ov(0, 0, 0, 0, 1, 1, 0);
      end else begin
        e.o = ov(0, 0, b && (k != int'(W) - 1), b && (k == int'(W) - 1), 0, 1, 0);
        sched.push_back(e);
        e = '0;
        e.m = rbit();
        e.o = ov(0, 0, 0, 0, 1, 1, 0);
      end
      e.last = (k == int'(W) - 1);
      sched.push_back(e);
    end
  endtask

  task automatic idle_decide(input logic run, input logic clb);
    ent_t l;
    if (run) begin
      build_run();
    end else if (clb) begin
      l = '0;
      l.m = rbit();
      l.o = ov(1, 0, 0, 0, 0, 0, 0);
      sched.push_back(l);
    end
  endtask

  task automatic step(input logic run, input logic clb, input bit rst_pulse);
    ent_t e;
    @(posedge Clk);
    #1;
    Run = run;
    ClearA_LoadB = clb;
    e = '0;
    e.m = rbit();
    if (sched.size() > 0) begin
      e = sched.pop_front();
      if (e.last) in_hold = 1'b1;
    end else if (in_hold) begin
      e.o = ov(0, 0, 0, 0, 0, 0, 1);
      if (!run) in_hold = 1'b0;
    end else begin
      idle_decide(run, clb);
    end
    M = e.m;
    exp_e = e;
    chk_en = 1'b1;
    if (rst_pulse) begin
      #1 Reset = 1'b1;
      #1;
      lit("async_reset_outputs", int'(outs), 0);
      Reset = 1'b0;
      sched.delete();
      in_hold = 1'b0;
      exp_e.o = '0;
      idle_decide(run, clb);
    end
    @(negedge Clk);
    #1;
  endtask

  task automatic run_seq(input int mode, input int ncyc, input int want_len,
                         output int first_done, output int n_add, output int n_sub,
                         output int n_shift, output int n_clrx, output int clrx_at,
                         output int sub_at, output int n_clrld);
    bits_mode = mode;
    first_done = -1;
    n_add = 0;
    n_sub = 0;
    n_shift = 0;
    n_clrx = 0;
    clrx_at = -1;
    sub_at = -1;
    n_clrld = 0;
    step(1'b1, 1'b0, 1'b0);
    lit("model_sched_len", sched.size(), want_len);
    for (int c = 1; c <= ncyc; c++) begin
      step(1'b1, rbit(), 1'b0);
      if (done && first_done < 0) first_done = c;
      n_add += int'(add);
      n_sub += int'(sub);
      n_shift += int'(shift);
      n_clrx += int'(clear_xa);
      n_clrld += int'(clr_ld);
      if (clear_xa && clrx_at < 0) clrx_at = c;
      if (sub) sub_at = c;
    end
    bits_mode = 0;
  endtask

  task automatic driver();
    int fd, na, ns, nsh, ncx, cxa, sa, ncl;
    logic [3:0] pat;
    repeat (2) @(posedge Clk);
    #1;
    lit("outputs_during_reset", int'(outs), 0);
    Reset = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    lit("first_cycle_after_reset", int'(outs), 0);
    step(1'b0, 1'b0, 1'b0);

    // M tied 1, Run held well past done
    run_seq(1, 24, 17, fd, na, ns, nsh, ncx, cxa, sa, ncl);
    lit("ones_done_at", fd, 18);
    lit("ones_add_cnt", na, 7);
    lit("ones_sub_cnt", ns, 1);
    lit("ones_sub_at", sa, 16);
    lit("ones_shift_cnt", nsh, 8);
    lit("ones_clear_xa_cnt", ncx, 1);
    lit("ones_clear_xa_at", cxa, 1);
    lit("clr_ld_while_busy", ncl, 0);
    step(1'b0, 1'b0, 1'b0);
    lit("hold_exit_cycle_done", int'(done), 1);

    // M tied 0; also a fresh run immediately after leaving HOLD
    run_seq(2, 20, Skip ? 9 : 17, fd, na, ns, nsh, ncx, cxa, sa, ncl);
    lit("zeros_done_at", fd, Skip ? 10 : 18);
    lit("zeros_add_sub", na + ns, 0);
    lit("zeros_shift_cnt", nsh, 8);
    lit("rerun_clear_xa_at", cxa, 1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    lit("idle_after_hold", int'(outs), 0);

    // Alternating bits 1,0,1,0,...
    run_seq(3, 20, Skip ? 13 : 17, fd, na, ns, nsh, ncx, cxa, sa, ncl);
    lit("alt_done_at", fd, Skip ? 14 : 18);
    lit("alt_add_cnt", na, 4);
    lit("alt_sub_cnt", ns, 0);
    lit("alt_shift_cnt", nsh, 8);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // ClearA_LoadB single pulse, then held high
    step(1'b0, 1'b1, 1'b0);
    lit("clb_pulse_same_cycle", int'(clr_ld), 0);
    step(1'b0, 1'b0, 1'b0);
    lit("clb_pulse_next_cycle", int'(clr_ld), 1);
    step(1'b0, 1'b0, 1'b0);
    lit("clb_pulse_after", int'(clr_ld), 0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0);
      pat[3-i] = clr_ld;
    end
    lit("clb_held_pattern", int'(pat), 4'b0101);
    step(1'b0, 1'b0, 1'b0);

    // Async reset during the 4th SHIFT (cycle 9), then a clean run proves cnt restarted
    bits_mode = 1;
    step(1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 8; c++) step(1'b1, 1'b0, 1'b0);
    bits_mode = 0;
    lit("pre_reset_exp_is_shift", int'(sched[0].o), int'(ov(0, 0, 0, 0, 1, 1, 0)));
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    lit("idle_after_reset", int'(outs), 0);
    run_seq(1, 19, 17, fd, na, ns, nsh, ncx, cxa, sa, ncl);
    lit("post_reset_done_at", fd, 18);
    step(1'b0, 1'b0, 1'b0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      step(($urandom % 3) != 0, rbit(), ($urandom % 300) == 0);
    end
    drv_done = 1'b1;
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge Clk);
      if (chk_en) begin
        checks++;
        if (outs !== exp_e.o) begin
          failures++;
          $display("FAIL outputs t=%0t got=%b want=%b (clr_ld,clear_xa,add,sub,shift,busy,done)",
                   $time, outs, exp_e.o);
        end
      end
    end
  endtask

  initial begin
    fork
      driver();
      compare_loop();
    join_any
    disable fork;
    if (!drv_done) $display("FAIL driver_incomplete got=0 want=1");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
